fifo_uart_tx: RTL and testbench

Downstream drain stage for the synchronous `fifo`: watches the FIFO `empty` flag, pops one word at a time through the FIFO read port and serialises it onto a single UART-style line (start bit, data LSB first, optional parity, stop bit). It is the FIFO's only reader, so the FIFO's `r_en`/`r_data` pair is owned entirely by this block.

---
 rtl/fifo_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: sole reader of a synchronous FIFO; pops one word at a time and sends it as a UART frame.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds one even-parity bit between the data and stop bits.
module fifo_uart_tx #(
    parameter int size         = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            empty,
    input  logic [size-1:0] r_data,
    output logic            r_en,
    output logic            tx,
    output logic            busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (size > 1) ? $clog2(size) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(size - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [size-1:0]   r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bitCnt;
    logic              w_baudDone;
    logic              w_bitLast;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_baudDone = (r_baud == BAUD_LAST);
    assign w_bitLast  = (r_bitCnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_nextState = POP;
                end
            end
            POP: begin
                w_nextState = LOAD;
            end
            LOAD: begin
                w_nextState = START;
            end
            START: begin
                if (w_baudDone) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_baudDone && w_bitLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_nextState = PARITY;
`else
                    w_nextState = STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (w_baudDone) begin
                    w_nextState = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baudDone) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Word capture, bit timing and shifting; the baud counter restarts at every bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_baud   <= '0;
            r_bitCnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                LOAD: begin
                    r_shift  <= r_data;
                    r_baud   <= '0;
                    r_bitCnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity <= ^r_data;
`endif
                end
                START: begin
                    if (w_baudDone) begin
                        r_baud   <= '0;
                        r_bitCnt <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baudDone) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (!w_bitLast) begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud <= '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state only, so reset forces tx high without waiting for a clock.
    always_comb begin
        tx   = 1'b1;
        r_en = 1'b0;
        busy = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            POP: begin
                r_en = 1'b1;
            end
            START: begin
                tx = 1'b0;
            end
            DATA: begin
                tx = r_shift[0];
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                tx = r_parity;
            end
`endif
            default: begin
                tx = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT and a monitor decodes every tx frame.
module tb_fifo_uart_tx;

    localparam int SIZE = 8;
    localparam int CPB  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = SIZE + 3;
`else
    localparam int NBITS = SIZE + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            empty  = 1'b1;
    logic [SIZE-1:0] r_data = '0;
    logic            r_en;
    logic            tx;
    logic            busy;

    fifo_uart_tx #(.size(SIZE), .CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .empty  (empty),
        .r_data (r_data),
        .r_en   (r_en),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Stimulus-owned mailboxes; the monitor only reads them.
    int            pushSeq  = 0;
    logic [SIZE:0] pushWord = '0;
    int            reqSeq   = 0;
    int            reqKind  = 0;
    int            reqAct   = 0;
    int            reqWant  = 0;
    string         reqName  = "";
    int            dropSeq  = 0;

    // Monitor-owned state.
    logic [SIZE-1:0] fifoQ[$];
    logic [SIZE:0]   expQ[$];
    int   pushSeen = 0, reqSeen = 0, dropSeen = 0;
    int   checks = 0, errors = 0, popCount = 0, framesDone = 0;
    logic frameBits [FRAME];
    int   cyc = 0, gap = 0, busyRun = 0, latCnt = -1;
    bit   collecting = 0, gapArmed = 0, renLatched = 0, seenReset = 0;

    task automatic checkOutput(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic evaluateFrame();
        logic [SIZE-1:0] data;
        logic [SIZE:0]   expWord;
        int              stable;
        stable = 1;
        for (int k = 0; k < NBITS; k++) begin
            for (int j = 1; j < CPB; j++) begin
                if (frameBits[k*CPB+j] != frameBits[k*CPB]) stable = 0;
            end
        end
        checkOutput("bit_width", stable, 1);
        checkOutput("start_bit", int'(frameBits[0]), 0);
        checkOutput("stop_bit", int'(frameBits[(NBITS-1)*CPB]), 1);
        for (int i = 0; i < SIZE; i++) data[i] = frameBits[(i+1)*CPB];
        checkOutput("frame_expected", (expQ.size() > 0) ? 1 : 0, 1);
        if (expQ.size() > 0) begin
            expWord = expQ.pop_front();
            checkOutput("frame_data", int'(data), int'(expWord[SIZE-1:0]));
`ifdef FIFO_UART_TX_PARITY_EN
            checkOutput("parity_bit", int'(frameBits[(SIZE+1)*CPB]), int'(expWord[SIZE]));
`endif
        end
        framesDone++;
    endtask

    // FIFO model on rising edges, monitor/scoreboard on falling edges, all in one process.
    initial begin
        forever begin
            @(clk);
            if (clk) begin
                if (pushSeq != pushSeen) begin
                    pushSeen = pushSeq;
                    fifoQ.push_back(pushWord[SIZE-1:0]);
                    expQ.push_back(pushWord);
                end
                if (rst && renLatched && fifoQ.size() > 0) r_data <= fifoQ.pop_front();
                renLatched = 1'b0;
                empty <= (fifoQ.size() == 0);
            end else begin
                if (!rst) begin
                    seenReset = 1;
                    checkOutput("reset_tx", int'(tx), 1);
                    checkOutput("reset_ren", int'(r_en), 0);
                    checkOutput("reset_busy", int'(busy), 0);
                    collecting = 0; gapArmed = 0; busyRun = 0; latCnt = -1; renLatched = 0;
                end else if (seenReset) begin
                    renLatched = r_en;
                    if (!busy) begin
                        checkOutput("idle_tx", int'(tx), 1);
                        checkOutput("idle_ren", int'(r_en), 0);
                    end
                    if (busy) begin
                        busyRun++;
                    end else if (busyRun > 0) begin
                        checkOutput("busy_len", busyRun, FRAME + 2);
                        busyRun = 0;
                    end
                    if (latCnt >= 0) begin
                        latCnt++;
                        if (latCnt == 2) begin
                            checkOutput("pop_latency", int'(tx), 0);
                            latCnt = -1;
                        end
                    end
                    if (r_en) begin
                        popCount++;
                        checkOutput("pop_nonempty", (fifoQ.size() > 0) ? 1 : 0, 1);
                        latCnt = 0;
                    end
                    if (collecting) begin
                        frameBits[cyc] = tx;
                        cyc++;
                        if (cyc == FRAME) begin
                            evaluateFrame();
                            collecting = 0;
                            gap = 0;
                            gapArmed = (fifoQ.size() > 0);
                        end
                    end else if (tx == 1'b0) begin
                        if (gapArmed) checkOutput("btb_gap", gap, 3);
                        gapArmed = 0;
                        frameBits[0] = 1'b0;
                        cyc = 1;
                        collecting = 1;
                    end else begin
                        gap++;
                    end
                end
                if (dropSeq != dropSeen) begin
                    dropSeen = dropSeq;
                    if (expQ.size() > 0) void'(expQ.pop_front());
                end
                if (reqSeq != reqSeen) begin
                    reqSeen = reqSeq;
                    case (reqKind)
                        1:       checkOutput(reqName, popCount, reqWant);
                        2:       checkOutput(reqName, framesDone, reqWant);
                        default: checkOutput(reqName, reqAct, reqWant);
                    endcase
                end
            end
        end
    end

    task automatic applyStimulus(input logic [SIZE-1:0] word, input logic par);
        @(posedge clk); #1;
        pushWord = {par, word};
        pushSeq++;
    endtask

    task automatic requestCheck(input int kind, input string name, input int act, input int want);
        @(posedge clk); #1;
        reqKind = kind;
        reqName = name;
        reqAct  = act;
        reqWant = want;
        reqSeq++;
        @(negedge clk); #1;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n;
        n = 0;
        while (framesDone < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        requestCheck(0, "frame_timeout", (framesDone >= target) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int n;
        bit startSeen;
        #1 rst = 1'b0;
        applyStimulus(8'hA5, 1'b0);
        repeat (20) @(posedge clk);
        requestCheck(1, "pops_in_reset", 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        waitFrames(1, 200);
        requestCheck(1, "pops_single", 0, 1);

        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h80, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b0);
        waitFrames(5, 800);
        requestCheck(1, "pops_btb", 0, 5);
        requestCheck(2, "frames_btb", 0, 5);

        repeat (1000) @(posedge clk);
        requestCheck(1, "pops_idle", 0, 5);

        applyStimulus(8'h3C, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 100);
        startSeen = (tx === 1'b0);
        repeat (16) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        dropSeq++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        requestCheck(0, "start_timeout", startSeen ? 1 : 0, 1);
        waitFrames(6, 300);
        requestCheck(1, "pops_after_reset", 0, 7);
        requestCheck(2, "frames_after_reset", 0, 6);

`ifdef FIFO_UART_TX_PARITY_EN
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h03, 1'b0);
        waitFrames(8, 400);
        requestCheck(1, "pops_parity", 0, 9);
`endif

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
